// File: rtl/ballot_scheduler.sv
// ballot_scheduler: voting session FSM plus round-robin booth arbiter with vote validation
module ballot_scheduler #(
  parameter int NUM_BOOTHS = 4,
  parameter int NUM_REPS   = 4,
  parameter int MAX_ID     = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           open_pulse,
  input  logic                           close_pulse,
  input  logic                           clear_pulse,
  input  logic [NUM_BOOTHS-1:0]          req,
  input  logic [4*NUM_BOOTHS-1:0]        voter_id,
  input  logic [NUM_REPS*NUM_BOOTHS-1:0] rep_sel,
  output logic [NUM_BOOTHS-1:0]          ack,
  output logic [NUM_BOOTHS-1:0]          nack,
  output logic [2:0]                     nack_code,
  output logic [NUM_REPS-1:0]            tally_inc,
  output logic                           tally_clr,
  output logic [1:0]                     session,
  output logic [3:0]                     voters_cast
);
  localparam int BW = $clog2(NUM_BOOTHS);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OPEN = 2'd1, S_CLOSED = 2'd2} sess_t;
  sess_t                 sess_q, sess_d;
  logic [MAX_ID:0]       seen_q, seen_d, id_oh;
  logic [3:0]            cast_q, cast_d, wid;
  logic [BW-1:0]         rr_q, rr_d, win;
  logic [NUM_BOOTHS-1:0] req_q, mask_q, avail, win_oh, ack_q, ack_d, nack_q, nack_d;
  logic [NUM_REPS-1:0]   inc_q, inc_d, wsel;
  logic [2:0]            code_q, code_d, code;
  logic                  clr_q, clr_d, gnt, found, acc;
  logic [3:0]            id_w [NUM_BOOTHS];
  logic [3:0]            id_q [NUM_BOOTHS];
  logic [NUM_REPS-1:0]   sel_w [NUM_BOOTHS];
  logic [NUM_REPS-1:0]   sel_q [NUM_BOOTHS];
  for (genvar g = 0; g < NUM_BOOTHS; g++) begin : g_unpack
    assign id_w[g]  = voter_id[4*g +: 4];
    assign sel_w[g] = rep_sel[NUM_REPS*g +: NUM_REPS];
  end
  // Round-robin pick among registered requests, skipping the booth answered last cycle
  always_comb begin
    avail = req_q & ~mask_q;
    found = 1'b0;
    win   = rr_q;
    for (int i = 0; i < NUM_BOOTHS; i++)
      if (!found && avail[BW'((int'(rr_q) + i) % NUM_BOOTHS)]) begin
        found = 1'b1;
        win   = BW'((int'(rr_q) + i) % NUM_BOOTHS);
      end
    gnt    = found && !(|(ack_q | nack_q));
    win_oh = {{(NUM_BOOTHS-1){1'b0}}, 1'b1} << win;
  end
  // Validate the winning booth's ballot in priority order
  always_comb begin
    wid   = id_q[win];
    wsel  = sel_q[win];
    id_oh = {{MAX_ID{1'b0}}, 1'b1} << wid;
    code  = sess_q != S_OPEN       ? 3'd4 :
            wid > 4'(MAX_ID)       ? 3'd1 :
            !$onehot(wsel)         ? 3'd3 :
            |(seen_q & id_oh)      ? 3'd2 : 3'd0;
    acc   = gnt && code == 3'd0;
  end
  // Session FSM, response pulses, bitmap, vote count and pointer next state
  always_comb begin
    sess_d = sess_q;
    clr_d  = 1'b0;
    ack_d  = acc ? win_oh : '0;
    nack_d = gnt && !acc ? win_oh : '0;
    code_d = gnt ? code : 3'd0;
    inc_d  = acc ? wsel : '0;
    seen_d = acc ? seen_q | id_oh : seen_q;
    cast_d = acc && cast_q != 4'hf ? cast_q + 4'd1 : cast_q;
    rr_d   = gnt ? (win == BW'(NUM_BOOTHS-1) ? '0 : win + 1'b1) : rr_q;
    if (clear_pulse && sess_q != S_OPEN) begin
      sess_d = S_IDLE;
      seen_d = '0;
      cast_d = 4'd0;
      clr_d  = 1'b1;
    end
    if (open_pulse && sess_q == S_IDLE) sess_d = S_OPEN;
    if (close_pulse && sess_q == S_OPEN) sess_d = S_CLOSED;
  end
  // State and registered outputs; reset drops every pulse immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sess_q <= S_IDLE;
      seen_q <= '0;
      cast_q <= 4'd0;
      rr_q   <= '0;
      req_q  <= '0;
      mask_q <= '0;
      ack_q  <= '0;
      nack_q <= '0;
      code_q <= 3'd0;
      inc_q  <= '0;
      clr_q  <= 1'b0;
      id_q   <= '{default: '0};
      sel_q  <= '{default: '0};
    end else begin
      sess_q <= sess_d;
      seen_q <= seen_d;
      cast_q <= cast_d;
      rr_q   <= rr_d;
      req_q  <= req;
      mask_q <= ack_q | nack_q;
      ack_q  <= ack_d;
      nack_q <= nack_d;
      code_q <= code_d;
      inc_q  <= inc_d;
      clr_q  <= clr_d;
      id_q   <= id_w;
      sel_q  <= sel_w;
    end
  end
  assign ack         = ack_q;
  assign nack        = nack_q;
  assign nack_code   = code_q;
  assign tally_inc   = inc_q;
  assign tally_clr   = clr_q;
  assign session     = sess_q;
  assign voters_cast = cast_q;
endmodule

// File: tb/tb_ballot_scheduler.sv
// tb_ballot_scheduler: directed scoreboard bench for the ballot scheduler
module tb_ballot_scheduler;
  logic clk = 1'b0, rst_n = 1'b1;
  logic open_pulse = 1'b0, close_pulse = 1'b0, clear_pulse = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] bid [4];
  logic [3:0] bsel [4];
  logic [15:0] voter_id, rep_sel;
  logic [3:0] ack, nack, tally_inc, voters_cast;
  logic [2:0] nack_code;
  logic tally_clr;
  logic [1:0] session;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {
    int cyc;
    logic [3:0] ack, nack;
    logic [2:0] code;
    logic [3:0] inc, vc;
    logic [1:0] sess;
  } resp_t;
  resp_t sbq[$];
  logic [3:0] e_id [5] = '{4'd3, 4'd10, 4'd4, 4'd4, 4'd12};
  logic [3:0] e_sel [5] = '{4'b0001, 4'b0001, 4'b0110, 4'b0000, 4'b0110};
  logic [2:0] e_code [5] = '{3'd2, 3'd1, 3'd3, 3'd3, 3'd1};
  assign voter_id = {bid[3], bid[2], bid[1], bid[0]};
  assign rep_sel  = {bsel[3], bsel[2], bsel[1], bsel[0]};

  ballot_scheduler dut (
    .clk(clk), .rst_n(rst_n), .open_pulse(open_pulse), .close_pulse(close_pulse),
    .clear_pulse(clear_pulse), .req(req), .voter_id(voter_id), .rep_sel(rep_sel),
    .ack(ack), .nack(nack), .nack_code(nack_code), .tally_inc(tally_inc),
    .tally_clr(tally_clr), .session(session), .voters_cast(voters_cast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] m);
    {open_pulse, close_pulse, clear_pulse} = m;
    tick();
    {open_pulse, close_pulse, clear_pulse} = 3'b0;
  endtask

  task automatic set_b(input logic [1:0] b, input logic [3:0] id, input logic [3:0] sel);
    bid[b]  = id;
    bsel[b] = sel;
  endtask

  task automatic expect_resp(input logic [1:0] b, input int k, input logic [2:0] code,
                             input logic [3:0] sel, input logic [3:0] vc, input logic [1:0] s);
    resp_t e;
    e.cyc  = cyc + 2 + 2 * k;
    e.ack  = code == 3'd0 ? 4'b1 << b : 4'b0;
    e.nack = code != 3'd0 ? 4'b1 << b : 4'b0;
    e.code = code;
    e.inc  = code == 3'd0 ? sel : 4'b0;
    e.vc   = vc;
    e.sess = s;
    sbq.push_back(e);
  endtask

  task automatic run(input logic [3:0] m, input int close_at);
    logic [3:0] seen;
    int k = 0;
    req = m;
    while (req != 4'b0 && k < 40) begin
      @(negedge clk);
      seen = ack | nack;
      tick();
      k++;
      req = req & ~seen;
      close_pulse = (k == close_at);
    end
    close_pulse = 1'b0;
    chk("run_timeout", int'(req), 0);
  endtask

  initial forever begin
    @(negedge clk);
    if ((ack | nack) != 4'b0) begin
      resp_t e;
      if (sbq.size() == 0) chk("unexpected_resp", int'(ack | nack), 0);
      else begin
        e = sbq.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("ack", int'(ack), int'(e.ack));
        chk("nack", int'(nack), int'(e.nack));
        chk("nack_code", int'(nack_code), int'(e.code));
        chk("tally_inc", int'(tally_inc), int'(e.inc));
        chk("voters_cast", int'(voters_cast), int'(e.vc));
        chk("session", int'(session), int'(e.sess));
      end
    end
  end

  initial begin
    bool_init();
    #2 rst_n = 1'b0;
    #20;
    chk("rst_session", int'(session), 0);
    chk("rst_cast", int'(voters_cast), 0);
    chk("rst_pulses", int'({ack, nack, tally_inc, tally_clr, nack_code}), 0);
    rst_n = 1'b1;
    tick();
    tick();
    strobe(3'b100);
    @(negedge clk);
    chk("open_session", int'(session), 1);
    tick();
    set_b(0, 4'd3, 4'b0010);
    expect_resp(0, 0, 3'd0, 4'b0010, 4'd1, 2'd1);
    run(4'b0001, 0);
    for (int i = 0; i < 5; i++) begin
      set_b(0, e_id[i], e_sel[i]);
      expect_resp(0, 0, e_code[i], e_sel[i], 4'd1, 2'd1);
      run(4'b0001, 0);
    end
    strobe(3'b001);
    @(negedge clk);
    chk("clr_open_pulse", int'(tally_clr), 0);
    chk("clr_open_session", int'(session), 1);
    chk("clr_open_cast", int'(voters_cast), 1);
    tick();
    set_b(3, 4'd8, 4'b1000);
    expect_resp(3, 0, 3'd0, 4'b1000, 4'd2, 2'd1);
    run(4'b1000, 0);
    set_b(0, 4'd0, 4'b0001);
    set_b(1, 4'd1, 4'b0010);
    set_b(2, 4'd2, 4'b0100);
    set_b(3, 4'd7, 4'b1000);
    for (int i = 0; i < 4; i++) expect_resp(2'(i), i, 3'd0, bsel[i], 4'(3 + i), 2'd1);
    run(4'b1111, 0);
    set_b(1, 4'd5, 4'b0010);
    set_b(2, 4'd5, 4'b0100);
    expect_resp(1, 0, 3'd0, 4'b0010, 4'd7, 2'd1);
    expect_resp(2, 1, 3'd2, 4'b0100, 4'd7, 2'd1);
    run(4'b0110, 0);
    set_b(3, 4'd9, 4'b0001);
    set_b(0, 4'd10, 4'b0001);
    set_b(1, 4'd0, 4'b0001);
    set_b(2, 4'd4, 4'b0100);
    expect_resp(3, 0, 3'd0, 4'b0001, 4'd8, 2'd1);
    expect_resp(0, 1, 3'd1, 4'b0001, 4'd8, 2'd1);
    expect_resp(1, 2, 3'd2, 4'b0001, 4'd8, 2'd1);
    expect_resp(2, 3, 3'd0, 4'b0100, 4'd9, 2'd1);
    run(4'b1111, 0);
    set_b(0, 4'd6, 4'b0010);
    expect_resp(0, 0, 3'd0, 4'b0010, 4'd10, 2'd1);
    run(4'b0001, 2);
    @(negedge clk);
    chk("closed_session", int'(session), 2);
    tick();
    set_b(1, 4'd1, 4'b0001);
    expect_resp(1, 0, 3'd4, 4'b0001, 4'd10, 2'd2);
    run(4'b0010, 0);
    strobe(3'b001);
    @(negedge clk);
    chk("clr_pulse", int'(tally_clr), 1);
    chk("clr_session", int'(session), 0);
    chk("clr_cast", int'(voters_cast), 0);
    tick();
    @(negedge clk);
    chk("clr_pulse_once", int'(tally_clr), 0);
    tick();
    set_b(2, 4'd3, 4'b0001);
    expect_resp(2, 0, 3'd4, 4'b0001, 4'd0, 2'd0);
    run(4'b0100, 0);
    strobe(3'b100);
    set_b(0, 4'd3, 4'b0100);
    expect_resp(0, 0, 3'd0, 4'b0100, 4'd1, 2'd1);
    run(4'b0001, 0);
    async_reset_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic bool_init();
    for (int i = 0; i < 4; i++) begin
      bid[i]  = 4'd0;
      bsel[i] = 4'd0;
    end
  endtask

  task automatic async_reset_burst();
    int got = 0;
    set_b(0, 4'd6, 4'b0001);
    set_b(1, 4'd5, 4'b0010);
    set_b(2, 4'd7, 4'b0100);
    set_b(3, 4'd8, 4'b1000);
    expect_resp(1, 0, 3'd0, 4'b0010, 4'd2, 2'd1);
    req = 4'b1111;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if ((ack | nack) != 4'b0) got = 1;
    end
    chk("async_first_resp", got, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_resp", int'({ack, nack, tally_inc}), 0);
    chk("async_rst_session", int'(session), 0);
    chk("async_rst_cast", int'(voters_cast), 0);
    req = 4'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_quiet", int'({ack, nack, tally_inc}), 0);
    chk("sb_drained", sbq.size(), 0);
  endtask
endmodule
